// File: rtl/pulse_conditioner_pkg.sv
// Shared edge-mode encodings and width helper for the pulse conditioner.
// Optional deglitch filter is enabled by defining PULSE_CONDITIONER_DEGLITCH_EN.
package pulse_conditioner_pkg;

  localparam logic [1:0] EDGE_RISING  = 2'b00;
  localparam logic [1:0] EDGE_FALLING = 2'b01;
  localparam logic [1:0] EDGE_BOTH    = 2'b10;
  localparam logic [1:0] EDGE_OFF     = 2'b11;

  // Minimum width of 1 keeps single-channel / zero-delay builds legal.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/pulse_conditioner_lane.sv
// One channel: synchroniser, optional deglitch (PULSE_CONDITIONER_DEGLITCH_EN),
// edge detect, programmable delay line, delay register and saturating counter.
module pulse_conditioner_lane
  import pulse_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int MAX_DELAY    = 15,
  parameter int DELAY_WIDTH  = clog2(MAX_DELAY + 1),
  parameter int COUNT_WIDTH  = 24,
  parameter int INVERT_INPUT = 1
`ifdef PULSE_CONDITIONER_DEGLITCH_EN
  , parameter int DEGLITCH_CYCLES = 3
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pulse_in,
  input  logic [1:0]             edge_mode,
  input  logic                   delay_wr,
  input  logic [DELAY_WIDTH-1:0] delay_val,
  input  logic                   count_clear,
  output logic                   pulse_out,
  output logic [COUNT_WIDTH-1:0] pulse_count
);

  logic                   raw;
  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_lvl;
  logic                   lvl;
  logic                   prev;
  logic                   edge_now;
  logic [MAX_DELAY:0]     taps;
  logic [DELAY_WIDTH-1:0] delay;

  assign raw      = (INVERT_INPUT != 0) ? ~pulse_in : pulse_in;
  assign sync_lvl = sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) sync <= '0;
    else     sync <= {sync[SYNC_STAGES-2:0], raw};
  end

`ifdef PULSE_CONDITIONER_DEGLITCH_EN
  localparam int DG_W = clog2(DEGLITCH_CYCLES + 1);

  logic [DG_W-1:0] dg_cnt;
  logic            dg_lvl;

  // A new level is accepted on its DEGLITCH_CYCLES-th consecutive sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      dg_cnt <= '0;
      dg_lvl <= 1'b0;
    end else if (sync_lvl == dg_lvl) begin
      dg_cnt <= '0;
    end else if (dg_cnt == DG_W'(DEGLITCH_CYCLES - 1)) begin
      dg_lvl <= sync_lvl;
      dg_cnt <= '0;
    end else begin
      dg_cnt <= dg_cnt + 1'b1;
    end
  end

  assign lvl = dg_lvl;
`else
  assign lvl = sync_lvl;
`endif

  always_comb begin
    edge_now = 1'b0;
    case (edge_mode)
      EDGE_RISING:  edge_now = lvl & ~prev;
      EDGE_FALLING: edge_now = ~lvl & prev;
      EDGE_BOTH:    edge_now = lvl ^ prev;
      default:      edge_now = 1'b0;
    endcase
  end

  // taps[0] is the registered edge pulse; higher taps are the delay history.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev      <= 1'b0;
      taps      <= '0;
      pulse_out <= 1'b0;
    end else begin
      prev      <= lvl;
      taps      <= {taps[MAX_DELAY-1:0], edge_now};
      pulse_out <= taps[delay];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           delay <= '0;
    else if (delay_wr) delay <= delay_val;
  end

  always_ff @(posedge clk) begin
    if (rst || count_clear)
      pulse_count <= '0;
    else if (pulse_out && (pulse_count != '1))
      pulse_count <= pulse_count + 1'b1;
  end

endmodule

// File: rtl/pulse_conditioner.sv
// Multi-channel pulse front-end: config decode/ack and output flattening around
// NUM_INPUTS lanes. Deglitch filter enabled by PULSE_CONDITIONER_DEGLITCH_EN.
module pulse_conditioner
  import pulse_conditioner_pkg::*;
#(
  parameter int NUM_INPUTS   = 12,
  parameter int SYNC_STAGES  = 2,
  parameter int MAX_DELAY    = 15,
  parameter int DELAY_WIDTH  = clog2(MAX_DELAY + 1),
  parameter int CH_WIDTH     = clog2(NUM_INPUTS),
  parameter int COUNT_WIDTH  = 24,
  parameter int INVERT_INPUT = 1
`ifdef PULSE_CONDITIONER_DEGLITCH_EN
  , parameter int DEGLITCH_CYCLES = 3
`endif
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_INPUTS-1:0]             pulse_in,
  input  logic [1:0]                        edge_mode,
  input  logic                              cfg_wr,
  input  logic [CH_WIDTH-1:0]               cfg_ch,
  input  logic [DELAY_WIDTH-1:0]            cfg_delay,
  output logic                              cfg_ack,
  input  logic                              count_clear,
  output logic [NUM_INPUTS-1:0]             pulse_out,
  output logic [NUM_INPUTS*COUNT_WIDTH-1:0] pulse_count
);

  logic                   ch_ok;
  logic [DELAY_WIDTH-1:0] delay_sat;

  assign ch_ok     = (32'(cfg_ch) < NUM_INPUTS);
  assign delay_sat = (32'(cfg_delay) > MAX_DELAY) ? DELAY_WIDTH'(MAX_DELAY) : cfg_delay;

  // Out-of-range channels are still acknowledged so the host never stalls.
  always_ff @(posedge clk) begin
    if (rst) cfg_ack <= 1'b0;
    else     cfg_ack <= cfg_wr;
  end

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
    logic                   lane_wr;
    logic [COUNT_WIDTH-1:0] lane_count;

    assign lane_wr = cfg_wr & ch_ok & (32'(cfg_ch) == i);

    pulse_conditioner_lane #(
      .SYNC_STAGES     (SYNC_STAGES),
      .MAX_DELAY       (MAX_DELAY),
      .DELAY_WIDTH     (DELAY_WIDTH),
      .COUNT_WIDTH     (COUNT_WIDTH),
      .INVERT_INPUT    (INVERT_INPUT)
`ifdef PULSE_CONDITIONER_DEGLITCH_EN
      , .DEGLITCH_CYCLES (DEGLITCH_CYCLES)
`endif
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .pulse_in    (pulse_in[i]),
      .edge_mode   (edge_mode),
      .delay_wr    (lane_wr),
      .delay_val   (delay_sat),
      .count_clear (count_clear),
      .pulse_out   (pulse_out[i]),
      .pulse_count (lane_count)
    );

    assign pulse_count[i*COUNT_WIDTH +: COUNT_WIDTH] = lane_count;
  end

endmodule

// File: doc/pulse_conditioner.md
Name: pulse_conditioner

Overview:
- Parametrised front-end between the raw detector inputs and the correlator core. Successor to the fixed one-cycle delay/edge-detect stage.
- Per channel: resynchronises the asynchronous input, detects edges in a selectable mode and applies a runtime-programmable delay of 0..MAX_DELAY cycles.
- Emits one-cycle pulses to the correlator and keeps saturating per-channel pulse counters for diagnostics.

Parameters:
- NUM_INPUTS, 12, number of channels.
- SYNC_STAGES, 2, synchroniser flops per channel (minimum 2).
- MAX_DELAY, 15, largest programmable delay in clk cycles.
- DELAY_WIDTH, clog2(MAX_DELAY+1), width of the delay config (derived).
- CH_WIDTH, clog2(NUM_INPUTS), width of the channel select (derived).
- COUNT_WIDTH, 24, per-channel counter width.
- INVERT_INPUT, 1, 1 means pulse_in is active-low and is inverted before the synchroniser.
- DEGLITCH_CYCLES, 3, stability window; used only with DEGLITCH_EN.

Ports:
- clk  in  1  system (PLL) clock.
- rst  in  1  synchronous reset, active-high.
- pulse_in  in  NUM_INPUTS  asynchronous detector inputs.
- edge_mode  in  2  edge select: 00 rising, 01 falling, 10 both, 11 disabled (normalised polarity); global to all channels.
- cfg_wr  in  1  delay write strobe.
- cfg_ch  in  CH_WIDTH  channel to configure.
- cfg_delay  in  DELAY_WIDTH  requested delay value.
- cfg_ack  out  1  one-cycle acknowledge of a write.
- count_clear  in  1  synchronous clear of all counters.
- pulse_out  out  NUM_INPUTS  conditioned one-cycle pulses.
- pulse_count  out  NUM_INPUTS*COUNT_WIDTH  flattened counters; channel i occupies [i*COUNT_WIDTH +: COUNT_WIDTH].

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - Synchroniser, deglitch and delay shift registers clear to 0, i.e. the normalised inactive level, so no spurious edge on release.
  - All delays are 0, all counters 0, pulse_out=0, cfg_ack=0.
- Normalisation: s = INVERT_INPUT ? ~pulse_in : pulse_in, then a SYNC_STAGES flop chain.
- Edge detect: compares the last synchroniser stage with a one-flop history, giving a registered edge pulse e.
  - Rising: cur & ~prev. Falling: ~cur & prev. Both: XOR. Disabled: 0.
  - A change of edge_mode takes effect on the next cycle. Flops are not cleared on a mode change.
- Delay line: per-channel shift register of MAX_DELAY+1 taps; tap0 = e.
  - pulse_out[i] is registered from tap[delay[i]].
  - Total latency from the input change to the pulse_out rising edge: SYNC_STAGES + 2 + delay[i] cycles (e.g. 4 with defaults and delay 0).
- Config handshake:
  - cfg_wr sampled high causes a write in that cycle; cfg_ack is high for exactly the next cycle.
  - Back-to-back writes are accepted every cycle.
  - cfg_ch >= NUM_INPUTS: no write, still acked.
  - cfg_delay > MAX_DELAY: saturated to MAX_DELAY.
  - New tap selection applies from the cycle after the write. The shift register is not flushed, so pulses already in flight may be skipped or emitted twice around the switch. This is accepted; the correlator must be idle during reconfiguration.
  - cfg_wr during rst is ignored and not acked.
- Counters:
  - Increment on each pulse_out assertion and saturate at 2^COUNT_WIDTH-1 (no wrap).
  - count_clear has priority over a simultaneous increment: the counter reads 0 next cycle and that pulse is not counted.
- Consecutive edges one cycle apart (both mode, toggling input) produce consecutive pulse_out cycles. No merging or loss.

Optional Feature:
- Macro: PULSE_CONDITIONER_DEGLITCH_EN.
- Defined: after the synchroniser, a per-channel counter passes a new level only once it has been stable for DEGLITCH_CYCLES consecutive cycles. Shorter excursions are discarded. Latency grows by DEGLITCH_CYCLES cycles.
- Undefined: the synchroniser output feeds edge detect directly; no counter logic is synthesised.

Decomposition:
- Shared package pulse_conditioner_pkg:
  - edge-mode localparams EDGE_RISING=2'b00, EDGE_FALLING=2'b01, EDGE_BOTH=2'b10, EDGE_OFF=2'b11;
  - a clog2 function for the derived widths.
- One sub-module, pulse_conditioner_lane: contains synchroniser, optional deglitch, edge detect, delay line, delay register and counter for one channel. It is instantiated NUM_INPUTS times by generate.
- The top holds only the config decode, cfg_ack and the output flattening.

Test Plan:
- Reset release with pulse_in held all-1 (active-low idle) -> pulse_out stays 0 and all counts 0 for 20 cycles.
- Channel 3, delay 0, rising mode, a 5-cycle active pulse -> exactly one pulse_out[3] high, 4 cycles after the input edge; count[3]=1.
- Write cfg_ch=7, cfg_delay=20 -> cfg_ack high the next cycle, stored delay 15; an edge appears 19 cycles later. A write with cfg_ch=12 -> acked, no channel changes.
- Both mode with the input toggling every cycle for 8 cycles -> 8 consecutive pulse_out cycles; count=8.
- COUNT_WIDTH=4 with 20 pulses -> count holds at 15. count_clear coincident with a pulse -> count reads 0 the next cycle.
- With PULSE_CONDITIONER_DEGLITCH_EN: a 2-cycle glitch -> no pulse; a 3-cycle level -> one pulse at latency 7.
